// File: rtl/vote_frame_collector_if.sv
// Bundle of the sample-input, frame-output and control signals of the
// vote frame collector.
//   master : serial sample source plus frame consumer (drives in_valid,
//            in_data, flush and frame_ready)
//   slave  : the collector (drives in_ready, frame_valid, numbers,
//            fill_count and timeout_err)
// numbers is unpacked [FRAME_LEN-1:0] so it can feed the voter directly.
interface vote_frame_collector_if #(
   parameter int DATA_W    = 4,
   parameter int FRAME_LEN = 13
);
   localparam int CNT_W = $clog2(FRAME_LEN + 1);

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              flush;
   logic              frame_ready;
   logic              frame_valid;
   logic [DATA_W-1:0] numbers [FRAME_LEN-1:0];
   logic [CNT_W-1:0]  fill_count;
   logic              timeout_err;

   modport master (
      output in_valid, in_data, flush, frame_ready,
      input  in_ready, frame_valid, numbers, fill_count, timeout_err
   );

   modport slave (
      input  in_valid, in_data, flush, frame_ready,
      output in_ready, frame_valid, numbers, fill_count, timeout_err
   );
endinterface

// File: rtl/vote_frame_collector.sv
// Collects FRAME_LEN serial samples into a frame for the majority voter and
// holds the complete frame stable under a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : vote_frame_collector_if.slave (sample in, frame out, flush)
// The first sample of a frame lands in numbers[FRAME_LEN-1], the last in
// numbers[0].
// Optional macro FRAME_TIMEOUT_EN: discards a partial frame after TIMEOUT
// consecutive idle cycles and pulses timeout_err; without it timeout_err
// is tied low and a partial frame waits indefinitely.
//
// state  | meaning
// S_FILL | accepting samples, in_ready=1, frame_valid=0
// S_FULL | complete frame held, in_ready=0, frame_valid=1
module vote_frame_collector #(
   parameter int DATA_W    = 4,
   parameter int FRAME_LEN = 13,
   parameter int TIMEOUT   = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   vote_frame_collector_if.slave  bus
);
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {S_FILL, S_FULL} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  fill_q, fill_d;
   logic [DATA_W-1:0] numbers_q [FRAME_LEN-1:0];
   logic [DATA_W-1:0] numbers_d [FRAME_LEN-1:0];
   logic [CNT_W-1:0]  wr_idx;

`ifdef FRAME_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             terr_q, terr_d;
`endif

   // Fill order runs from the top entry down.
   assign wr_idx = LAST - fill_q;

   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      numbers_d = numbers_q;
`ifdef FRAME_TIMEOUT_EN
      // Clearing by default makes the timer count only consecutive idle cycles.
      timer_d   = '0;
      terr_d    = 1'b0;
`endif
      if (bus.flush) begin
         state_d = S_FILL;
         fill_d  = '0;
         for (int i = 0; i < FRAME_LEN; i++) numbers_d[i] = '0;
      end else if (state_q == S_FULL) begin
         if (bus.frame_ready) begin
            // Entries are left in place and overwritten by the next frame.
            state_d = S_FILL;
            fill_d  = '0;
         end
      end else if (bus.in_valid) begin
         numbers_d[wr_idx] = bus.in_data;
         fill_d            = fill_q + CNT_W'(1);
         if (fill_q == LAST) state_d = S_FULL;
      end
`ifdef FRAME_TIMEOUT_EN
      else if (fill_q != '0) begin
         if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            fill_d = '0;
            terr_d = 1'b1;
            for (int i = 0; i < FRAME_LEN; i++) numbers_d[i] = '0;
         end else begin
            timer_d = timer_q + TMR_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FILL;
         fill_q  <= '0;
         for (int i = 0; i < FRAME_LEN; i++) numbers_q[i] <= '0;
`ifdef FRAME_TIMEOUT_EN
         timer_q <= '0;
         terr_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         numbers_q <= numbers_d;
`ifdef FRAME_TIMEOUT_EN
         timer_q   <= timer_d;
         terr_q    <= terr_d;
`endif
      end
   end

   assign bus.in_ready    = (state_q == S_FILL);
   assign bus.frame_valid = (state_q == S_FULL);
   assign bus.fill_count  = fill_q;
   assign bus.numbers     = numbers_q;
`ifdef FRAME_TIMEOUT_EN
   assign bus.timeout_err = terr_q;
`else
   assign bus.timeout_err = 1'b0;
`endif
endmodule
